// File: rtl/ibex_multdiv_arbiter_if.sv
// ibex_multdiv_arbiter_if: requester-side request/response bus of the shared multdiv arbiter.
// Per-requester fields are packed side by side, requester i at slice i.
interface ibex_multdiv_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [2*NUM_REQ-1:0]  req_operator_i;
    logic [2*NUM_REQ-1:0]  req_signed_mode_i;
    logic [32*NUM_REQ-1:0] req_op_a_i;
    logic [32*NUM_REQ-1:0] req_op_b_i;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [NUM_REQ-1:0]    rsp_ready_i;
    logic [31:0]           rsp_result_o;
    logic                  rsp_err_o;
    modport master (
        output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o
    );
    modport slave (
        input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o
    );
endinterface

// File: rtl/ibex_multdiv_arbiter.sv
// ibex_multdiv_arbiter: round-robin sharing of one ibex_multdiv_slow between NUM_REQ requesters.
// Define MULTDIV_ARB_TIMEOUT_EN to abort ops that exceed TIMEOUT_CYCLES with rsp_err_o set.
module ibex_multdiv_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ibex_multdiv_arbiter_if.slave bus,
    output logic                 md_mult_en_o,
    output logic                 md_div_en_o,
    output logic [1:0]           md_operator_o,
    output logic [1:0]           md_signed_mode_o,
    output logic [31:0]          md_op_a_o,
    output logic [31:0]          md_op_b_o,
    output logic                 md_ready_id_o,
    input  logic                 md_valid_i,
    input  logic [31:0]          md_result_i
);
    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e          state;
    logic [IW-1:0]   ptr, gnt, pick, idx;
    logic            found, timeout;
    logic [1:0]      op_sel, sm_sel;
    logic [31:0]     a_sel, b_sel;

    // first valid requester at or after the round-robin pointer, plus its operation fields
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        idx    = '0;
        op_sel = '0;
        sm_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (!found && bus.req_valid_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IW'(k) == pick) begin
                op_sel = bus.req_operator_i[2*k +: 2];
                sm_sel = bus.req_signed_mode_i[2*k +: 2];
                a_sel  = bus.req_op_a_i[32*k +: 32];
                b_sel  = bus.req_op_b_i[32*k +: 32];
            end
        end
    end

    assign bus.req_ready_o = (rst_ni && state == IDLE && found) ? NUM_REQ'(1) << pick : '0;

`ifdef MULTDIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_i) begin
        cnt <= (!rst_ni || state != ISSUE) ? '0 : cnt + 1'b1;
    end
    assign timeout = state == ISSUE && !md_valid_i && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state            <= IDLE;
            ptr              <= '0;
            gnt              <= '0;
            bus.rsp_valid_o  <= '0;
            bus.rsp_result_o <= '0;
            bus.rsp_err_o    <= 1'b0;
            md_mult_en_o     <= 1'b0;
            md_div_en_o      <= 1'b0;
            md_operator_o    <= '0;
            md_signed_mode_o <= '0;
            md_op_a_o        <= '0;
            md_op_b_o        <= '0;
            md_ready_id_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state            <= ISSUE;
                    gnt              <= pick;
                    ptr              <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    md_operator_o    <= op_sel;
                    md_signed_mode_o <= sm_sel;
                    md_op_a_o        <= a_sel;
                    md_op_b_o        <= b_sel;
                    md_mult_en_o     <= !op_sel[1];
                    md_div_en_o      <= op_sel[1];
                    md_ready_id_o    <= 1'b1;
                end
                ISSUE: if (md_valid_i || timeout) begin
                    state            <= RESP;
                    md_mult_en_o     <= 1'b0;
                    md_div_en_o      <= 1'b0;
                    md_ready_id_o    <= 1'b0;
                    bus.rsp_result_o <= md_valid_i ? md_result_i : '0;
                    bus.rsp_err_o    <= timeout;
                    bus.rsp_valid_o  <= NUM_REQ'(1) << gnt;
                end
                RESP: if (bus.rsp_ready_i[gnt]) begin
                    state           <= IDLE;
                    bus.rsp_valid_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// tb_ibex_multdiv_arbiter: directed and random checks of the multdiv arbiter against a queue-based
// round-robin model and an arithmetic multdiv stand-in; covers MULTDIV_ARB_TIMEOUT_EN when defined.
module tb_ibex_multdiv_arbiter;
    localparam int N = 2;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_multdiv_arbiter_if #(.NUM_REQ(N)) bus ();
    logic        md_mult_en, md_div_en, md_ready_id;
    logic        md_valid = 1'b0;
    logic [1:0]  md_operator, md_sm;
    logic [31:0] md_a, md_b;
    logic [31:0] md_result = '0;

    ibex_multdiv_arbiter #(.NUM_REQ(N)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus),
        .md_mult_en_o(md_mult_en), .md_div_en_o(md_div_en), .md_operator_o(md_operator),
        .md_signed_mode_o(md_sm), .md_op_a_o(md_a), .md_op_b_o(md_b), .md_ready_id_o(md_ready_id),
        .md_valid_i(md_valid), .md_result_i(md_result)
    );

    int   total = 0, bad = 0, ref_ptr = 0, lat = 0;
    bit   stall = 1'b0, busy = 1'b0;
    txn_t q [N][$];

    function automatic logic [31:0] ref_md(logic [1:0] op, logic [1:0] sm, logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        int ia, ib;
        bit sgn;
        sa = sm[0] ? longint'(signed'(a)) : longint'(a);
        sb = sm[1] ? longint'(signed'(b)) : longint'(b);
        p = 64'(sa * sb);
        ia = int'(a);
        ib = int'(b);
        sgn = sm == 2'b11;
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: return b == 0 ? 32'hFFFF_FFFF : sgn ? ((a == 32'h8000_0000 && b == '1) ? a : 32'(ia / ib)) : a / b;
            default: return b == 0 ? a : sgn ? ((a == 32'h8000_0000 && b == '1) ? 32'd0 : 32'(ia % ib)) : a % b;
        endcase
    endfunction

    function automatic txn_t mk(logic [1:0] op, logic [1:0] sm, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
        txn_t t;
        t.op = op; t.sm = sm; t.a = a; t.b = b; t.exp = exp;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [1:0] op, sm;
        logic [31:0] a, b;
        op = 2'($urandom_range(0, 3));
        sm = op[1] ? ($urandom_range(0, 1) ? 2'b11 : 2'b00) : 2'($urandom);
        a = $urandom_range(0, 7) == 0 ? 32'h8000_0000 : $urandom;
        case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom_range(1, 20);
            default: b = $urandom;
        endcase
        return mk(op, sm, a, b, ref_md(op, sm, a, b));
    endfunction

    // multdiv stand-in: random latency, result from the latched operands it is handed
    always @(negedge clk) begin
        if (!rst_n || !(md_mult_en || md_div_en)) begin
            busy = 1'b0;
            md_valid = 1'b0;
        end else if (!busy) begin
            busy = 1'b1;
            lat = $urandom_range(1, 5);
        end else if (lat > 1) begin
            lat--;
        end else if (!stall) begin
            md_valid = 1'b1;
            md_result = ref_md(md_operator, md_sm, md_a, md_b);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        for (int r = 0; r < N; r++) begin
            if (q[r].size() > 0) begin
                bus.req_valid_i[r] = 1'b1;
                bus.req_operator_i[2*r +: 2] = q[r][0].op;
                bus.req_signed_mode_i[2*r +: 2] = q[r][0].sm;
                bus.req_op_a_i[32*r +: 32] = q[r][0].a;
                bus.req_op_b_i[32*r +: 32] = q[r][0].b;
            end else begin
                bus.req_valid_i[r] = 1'b0;
                bus.req_operator_i[2*r +: 2] = 2'($urandom);
                bus.req_signed_mode_i[2*r +: 2] = 2'($urandom);
                bus.req_op_a_i[32*r +: 32] = $urandom;
                bus.req_op_b_i[32*r +: 32] = $urandom;
            end
        end
    endtask

    function automatic int ref_pick();
        for (int i = 0; i < N; i++)
            if (q[(ref_ptr + i) % N].size() > 0) return (ref_ptr + i) % N;
        return 0;
    endfunction

    task automatic chk_reset();
        chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_result", bus.rsp_result_o, 0);
        chk("rst_rsp_err", bus.rsp_err_o, 0);
        chk("rst_en", {md_mult_en, md_div_en, md_ready_id}, 0);
        chk("rst_opmode", {md_operator, md_sm}, 0);
        chk("rst_op_a", md_a, 0);
        chk("rst_op_b", md_b, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_req();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
        ref_ptr = 0;
    endtask

    // one full transaction; entered and left shortly after a falling edge
    task automatic txn(input int hold);
        int g, n;
        bit ok;
        txn_t t;
        drive_req();
        #1;
        g = ref_pick();
        chk("grant", bus.req_ready_o, 64'd1 << g);
        t = q[g].pop_front();
        ref_ptr = (g + 1) % N;
        @(negedge clk);
        drive_req();
        #1;
        chk("issue_ready", bus.req_ready_o, 0);
        chk("issue_en", {md_mult_en, md_div_en, md_ready_id}, {t.op < 2, t.op >= 2, 1'b1});
        chk("issue_opmode", {md_operator, md_sm}, {t.op, t.sm});
        chk("issue_op_a", md_a, t.a);
        chk("issue_op_b", md_b, t.b);
        ok = 1'b1;
        n = 0;
        while (bus.rsp_valid_o === '0 && n < 200) begin
            ok &= md_a === t.a && md_b === t.b && bus.req_ready_o === '0;
            @(negedge clk);
            #1;
            n++;
        end
        chk("issue_stable", ok, 1);
        chk("rsp_in_time", n < 200, 1);
        chk("rsp_valid", bus.rsp_valid_o, 64'd1 << g);
        chk("rsp_result", bus.rsp_result_o, t.exp);
        chk("rsp_err", bus.rsp_err_o, 0);
        chk("resp_en_off", {md_mult_en, md_div_en, md_ready_id}, 0);
        ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready_i = ~(N'(1) << g);
            @(negedge clk);
            #1;
            ok &= bus.req_ready_o === '0 && bus.rsp_valid_o === N'(1) << g && bus.rsp_result_o === t.exp;
        end
        if (hold > 0) chk("resp_hold", ok, 1);
        bus.rsp_ready_i = N'(1) << g;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = '0;
        #1;
        chk("rsp_drop", bus.rsp_valid_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid_i = '1;
        bus.req_operator_i = '0;
        bus.req_signed_mode_i = '0;
        bus.req_op_a_i = '0;
        bus.req_op_b_i = '0;
        bus.rsp_ready_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset();
        drive_req();
        rst_n = 1'b1;

        q[0].push_back(mk(2'd0, 2'b00, 32'd7, 32'd6, 32'd42));
        txn(0);

        do_reset();
        q[0].push_back(mk(2'd2, 2'b00, 32'd100, 32'd7, 32'd14));
        q[1].push_back(mk(2'd3, 2'b00, 32'd100, 32'd7, 32'd2));
        txn(0);
        txn(0);

        for (int i = 0; i < 2; i++)
            for (int r = 0; r < N; r++) q[r].push_back(rand_txn());
        repeat (4) txn(0);

        q[1].push_back(mk(2'd2, 2'b11, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF));
        q[1].push_back(mk(2'd3, 2'b00, 32'd5, 32'd0, 32'd5));
        txn(0);
        txn(0);

        q[0].push_back(rand_txn());
        q[1].push_back(rand_txn());
        txn(10);
        txn(0);

        for (int it = 0; it < 25; it++) begin
            for (int r = 0; r < N; r++)
                if ($urandom_range(0, 1) == 1) q[r].push_back(rand_txn());
            while (q[0].size() + q[1].size() > 0) txn($urandom_range(0, 3));
        end

        do_reset();
        stall = 1'b1;
        q[0].push_back(mk(2'd0, 2'b00, 32'd3, 32'd4, 32'd12));
        drive_req();
        #1;
        chk("abort_grant", bus.req_ready_o, 1);
        q[0].delete();
        @(negedge clk);
        drive_req();
        repeat (5) @(negedge clk);
        #1;
        chk("abort_issue_en", {md_mult_en, md_div_en}, 2'b10);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
        ref_ptr = 0;
        repeat (5) @(negedge clk);
        #1;
        chk("abort_no_reissue", {md_mult_en, md_div_en, bus.rsp_valid_o}, 0);

        q[0].push_back(mk(2'd2, 2'b00, 32'd9, 32'd3, 32'd3));
        drive_req();
        #1;
        chk("stall_grant", bus.req_ready_o, 1);
        q[0].delete();
        n = 0;
        do begin
            @(negedge clk);
            drive_req();
            #1;
            n++;
        end while (bus.rsp_valid_o === '0 && n < 200);
`ifdef MULTDIV_ARB_TIMEOUT_EN
        chk("timeout_cycles", n, 65);
        chk("timeout_valid", bus.rsp_valid_o, 1);
        chk("timeout_err", bus.rsp_err_o, 1);
        chk("timeout_result", bus.rsp_result_o, 0);
        chk("timeout_en_off", {md_mult_en, md_div_en}, 0);
        bus.rsp_ready_i = 2'b01;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = '0;
        #1;
        chk("timeout_drop", bus.rsp_valid_o, 0);
`else
        chk("stall_waits", n, 200);
        chk("stall_en", {md_mult_en, md_div_en, md_ready_id}, 3'b011);
`endif
        stall = 1'b0;
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
